// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;
endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the sequential divider.
// The master issues start with operands; the slave returns busy, done and the result.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic             sign_en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, sign_en, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, sign_en, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, subtract the divisor when it fits.
// Purely combinational; no handshake.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;

  // rem_in < divisor holds on entry, so the difference always fits in WIDTH bits.
  assign shifted = {rem_in, din};
  assign q_bit   = (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// Sequential signed/unsigned divider, one quotient bit per cycle; done WIDTH+1 cycles after start (1 for b==0).
// start is accepted only in IDLE; requests arriving while an operation runs are dropped.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             neg_q;
  logic             neg_r;
  logic             busy_r;
  logic             done_r;
  logic             div_zero_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .din     (mag_a[cnt]),
    .divisor (mag_b),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mag_a      <= '0;
      mag_b      <= '0;
      rem        <= '0;
      quo        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg_q      <= bus.sign_en & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r      <= bus.sign_en & bus.a[WIDTH-1];
            mag_a      <= (bus.sign_en && bus.a[WIDTH-1]) ? -bus.a : bus.a;
            mag_b      <= (bus.sign_en && bus.b[WIDTH-1]) ? -bus.b : bus.b;
            rem        <= '0;
            quo        <= '0;
            cnt        <= CNT_W'(WIDTH - 1);
            busy_r     <= 1'b1;
            div_zero_r <= (bus.b == '0);
            // A zero divisor goes straight to FIX, which then leaves hi/lo alone.
            state      <= (bus.b == '0) ? FIX : RUN;
          end
        end
        RUN: begin
          rem <= step_rem;
          quo <= {quo[WIDTH-2:0], step_q};
          if (cnt == '0) begin
            // busy drops as the last step completes, so it covers exactly the WIDTH step cycles.
            busy_r <= 1'b0;
            state  <= FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        FIX: begin
          if (!div_zero_r) begin
            lo_r <= neg_q ? -quo : quo;
            hi_r <= neg_r ? -rem : rem;
          end
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (WIDTH >= 4).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH), width of the internal bit counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request; operands sampled with it.
REQ-006 sign_en  input  1  1 = signed (div) operation, 0 = unsigned (divu) operation; sampled with start.
REQ-007 a  input  WIDTH  dividend.
REQ-008 b  input  WIDTH  divisor.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when hi/lo/div_zero are valid.
REQ-011 div_zero  output  1  divide-by-zero flag, valid with done, held until next accepted start.
REQ-012 hi  output  WIDTH  remainder.
REQ-013 lo  output  WIDTH  quotient.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FIX; only IDLE accepts start.
REQ-015 start in IDLE at edge E0: latch sign_en, latch magnitudes of a and b (two's-complement negate if sign_en and MSB set), clear partial remainder/quotient, counter = WIDTH-1, clear div_zero, enter RUN, busy=1.
REQ-016 RUN: one restoring step per cycle (shift remainder left, insert dividend bit[counter], subtract divisor if remainder >= divisor, set quotient bit); counter decrements; after the step with counter==0 enter FIX.
REQ-017 FIX: apply signs (quotient negated iff sign_en and a/b MSBs differ; remainder negated iff sign_en and a MSB set), write lo/hi, pulse done, busy=0, return to IDLE.
REQ-018 Latency: done high in the cycle following edge E0+WIDTH+1; back-to-back start accepted in the same cycle done is high.
REQ-019 Quotient SHALL truncate toward zero; remainder sign SHALL follow dividend; hi/lo are WIDTH bits, overflow wraps.
REQ-020 Signed most-negative / -1 SHALL yield lo = most-negative value, hi = 0, div_zero = 0.
REQ-021 b == 0 at start: skip RUN, div_zero=1, done pulse at E0+1 (latency 1), hi/lo unchanged, busy low after E0+1.
REQ-022 start while busy SHALL be ignored with no effect on the running operation.
REQ-023 hi/lo SHALL hold their value between operations; changed only in FIX or reset.
REQ-024 done SHALL never be high for two consecutive cycles from a single start.

Reset
REQ-025 reset SHALL force IDLE immediately, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0, internal registers 0.
REQ-026 reset mid-operation SHALL abort it; no done pulse for the aborted operation.
REQ-027 start coincident with reset SHALL be ignored.

Structure
REQ-028 SHALL use a shared package div_pkg containing the FSM state typedef (IDLE, RUN, FIX) and the default WIDTH constant.
REQ-029 SHALL instantiate one combinational sub-module div_step (one restoring shift/compare/subtract step, parameterised by WIDTH); everything else in seq_divider.

Verification
REQ-030 WIDTH=32, signed, a=7, b=2 -> lo=3, hi=1, done exactly 33 cycles after start edge, busy high 32 cycles.
REQ-031 signed, a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
REQ-032 unsigned, a=0xFFFFFFFE, b=2 -> lo=0x7FFFFFFF, hi=0; signed same operands -> lo=0xFFFFFFFF, hi=0.
REQ-033 signed a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0; then b=0 -> div_zero=1, done after 1 cycle, hi/lo still 0x00000000/0x80000000.
REQ-034 start 7/2, assert reset at cycle 10 -> busy=0, hi=lo=0 immediately, no done; new start 9/4 -> lo=2, hi=1.
REQ-035 start 100/7, second start 5/5 at cycle 5 -> ignored; lo=14, hi=2; start 5/5 in done cycle -> lo=1, hi=0 33 cycles later.
